// File: rtl/iter_divider.sv
// iter_divider
//   Multi-cycle RV32M divide unit (DIV, DIVU, REM, REMU). Restoring division,
//   one quotient bit per cycle, WIDTH iterations. It sits beside the ALU and
//   stalls the core through o_busy while a divide is in flight.
//
// Ports
//   i_clk     in   1      clock, rising edge
//   i_rst     in   1      asynchronous active-high reset
//   i_start   in   1      request, sampled only in IDLE
//   i_op      in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_a       in   WIDTH  dividend
//   i_b       in   WIDTH  divisor
//   o_busy    out  1      high from the cycle after accept through the o_valid cycle
//   o_valid   out  1      one-cycle result strobe
//   o_result  out  WIDTH  quotient or remainder; holds until the next result
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for i_start; operands and op captured on accept
// S_CALC | one restoring step per cycle, cnt_q counts down from WIDTH
// S_DONE | o_valid high for this one cycle, then back to S_IDLE
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] b_q;
  logic             rem_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             valid_q;
  logic [WIDTH-1:0] result_q;

  // Accept-time decode
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             ovf;

  always_comb begin
    is_signed = ~i_op[0];
    a_neg     = is_signed & i_a[WIDTH-1];
    b_neg     = is_signed & i_b[WIDTH-1];
    a_mag     = a_neg ? (~i_a + 1'b1) : i_a;
    b_mag     = b_neg ? (~i_b + 1'b1) : i_b;
    ovf       = is_signed && (i_a == MIN_VAL) && (i_b == {WIDTH{1'b1}});
  end

  // One restoring step. The shifted partial remainder is WIDTH+1 bits
  // {s_hi, s_lo}. The divisor magnitude fits in WIDTH bits, so the trial
  // subtract splits into a WIDTH-bit subtract on s_lo plus s_hi: the step
  // has no borrow (carry=1) when s_hi is set or the low subtract does not
  // borrow. When carry=1 the trial result is below the divisor, so its top
  // bit is zero and only d_lo needs keeping.
  logic             s_hi;
  logic [WIDTH-1:0] s_lo;
  logic             borrow_lo;
  logic [WIDTH-1:0] d_lo;
  logic             carry;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  always_comb begin
    s_hi               = r_q[WIDTH-1];
    s_lo               = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    {borrow_lo, d_lo}  = {1'b0, s_lo} - {1'b0, b_q};
    carry              = s_hi | ~borrow_lo;
    r_d                = carry ? d_lo : s_lo;
    q_d                = {q_q[WIDTH-2:0], carry};
    quo_fix            = neg_quo_q ? (~q_d + 1'b1) : q_d;
    rem_fix            = neg_rem_q ? (~r_d + 1'b1) : r_d;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      b_q       <= '0;
      rem_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            busy_q    <= 1'b1;
            rem_q     <= i_op[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            r_q       <= '0;
            q_q       <= a_mag;
            b_q       <= b_mag;
            if (i_b == '0) begin
              // RISC-V divide by zero: quotient all ones, remainder is the raw dividend
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= i_op[1] ? i_a : {WIDTH{1'b1}};
            end else if (ovf) begin
              state_q  <= S_DONE;
              valid_q  <= 1'b1;
              result_q <= i_op[1] ? '0 : MIN_VAL;
            end else begin
              state_q <= S_CALC;
              cnt_q   <= CW'(WIDTH);
            end
          end
        end
        S_CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q  <= S_DONE;
            valid_q  <= 1'b1;
            result_q <= rem_q ? rem_fix : quo_fix;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider. Stimulus pushes the hand-computed result
// and the cycle in which o_valid must appear; the monitor pops on o_valid.
module tb_iter_divider;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [1:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_result;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  iter_divider #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every o_valid must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1 result 0x%08h expected no result", o_result);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_result"}, o_result, mon_e.res);
        check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.due));
        check({mon_e.name, "_busy"}, {31'd0, o_busy}, 32'd1);
      end
    end
  end

  // Drive a request during one cycle (cycle 0) and record the expected result.
  task automatic send(input string nm, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    i_start = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    e.res   = exp;
    e.due   = cyc + lat;
    e.name  = nm;
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", nm, sb.size());
      sb.delete();
    end
    @(negedge clk);
    #1;
    check({nm, "_idle_busy"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    send(nm, op, a, b, exp, lat);
    wait_done(nm);
  endtask

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_op    = 2'b00;
    i_a     = '0;
    i_b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, o_busy},  32'd0);
    check("reset_valid",  {31'd0, o_valid}, 32'd0);
    check("reset_result", o_result,         32'd0);
    i_rst = 1'b0;

    run("divu_100_7",   OP_DIVU, 32'd100,       32'd7,          32'd14,         33);
    run("remu_100_7",   OP_REMU, 32'd100,       32'd7,          32'd2,          33);
    run("div_m7_2",     OP_DIV,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFD,   33);
    run("rem_m7_2",     OP_REM,  32'hFFFFFFF9,  32'd2,          32'hFFFFFFFF,   33);
    run("rem_7_m2",     OP_REM,  32'd7,         32'hFFFFFFFE,   32'd1,          33);
    run("div_7_m2",     OP_DIV,  32'd7,         32'hFFFFFFFE,   32'hFFFFFFFD,   33);
    run("div_m100_m7",  OP_DIV,  32'hFFFFFF9C,  32'hFFFFFFF9,   32'd14,         33);
    run("rem_m100_m7",  OP_REM,  32'hFFFFFF9C,  32'hFFFFFFF9,   32'hFFFFFFFE,   33);
    run("divu_5_0",     OP_DIVU, 32'd5,         32'd0,          32'hFFFFFFFF,   1);
    run("rem_5_0",      OP_REM,  32'd5,         32'd0,          32'd5,          1);
    run("div_m5_0",     OP_DIV,  32'hFFFFFFFB,  32'd0,          32'hFFFFFFFF,   1);
    run("remu_m5_0",    OP_REMU, 32'hFFFFFFFB,  32'd0,          32'hFFFFFFFB,   1);
    run("div_ovf",      OP_DIV,  32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1);
    run("rem_ovf",      OP_REM,  32'h80000000,  32'hFFFFFFFF,   32'd0,          1);
    run("divu_min_m1",  OP_DIVU, 32'h80000000,  32'hFFFFFFFF,   32'd0,          33);
    run("remu_min_m1",  OP_REMU, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   33);
    run("div_min_1",    OP_DIV,  32'h80000000,  32'd1,          32'h80000000,   33);
    run("divu_7_100",   OP_DIVU, 32'd7,         32'd100,        32'd0,          33);
    run("remu_7_100",   OP_REMU, 32'd7,         32'd100,        32'd7,          33);

    // Back-to-back: special case result then a normal divide immediately after.
    send("b2b_div0", OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, 1);
    @(negedge clk);
    #1;
    check("b2b_done_busy", {31'd0, o_busy}, 32'd0);
    run("b2b_divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Start pulsed mid-CALC with different operands must be ignored.
    send("ignore_divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    repeat (5) @(negedge clk);
    check("calc_busy", {31'd0, o_busy}, 32'd1);
    i_start = 1'b1;
    i_op    = OP_DIV;
    i_a     = 32'd9;
    i_b     = 32'd0;
    @(negedge clk);
    i_start = 1'b0;
    wait_done("ignore_divu_100_7");
    repeat (3) @(negedge clk);
    check("ignore_no_extra", 32'(sb.size()), 32'd0);

    // Reset in cycle 10 of CALC aborts without a result.
    @(negedge clk);
    i_start = 1'b1;
    i_op    = OP_DIVU;
    i_a     = 32'd1000;
    i_b     = 32'd3;
    @(negedge clk);
    i_start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_abort_busy", {31'd0, o_busy}, 32'd1);
    #2;
    i_rst = 1'b1;
    #1;
    check("abort_busy",  {31'd0, o_busy},  32'd0);
    check("abort_valid", {31'd0, o_valid}, 32'd0);
    @(negedge clk);
    i_rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_busy_later", {31'd0, o_busy}, 32'd0);
    run("post_abort_divu", OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
